// File: rtl/lsu_pkg.sv
// LSU shared types: per-slot uop layout, access-size encodings and the NOP uop.
package lsu_pkg;

  // Immediate width carried in every uop; the stage's IMM_W parameter must match it.
  localparam int unsigned LSU_IMM_W = 12;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  typedef struct packed {
    logic                 is_nop;
    logic                 is_load;
    logic                 zero_ext;
    logic [1:0]           size;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [LSU_IMM_W-1:0] imm;
  } lsu_uop_t;

  localparam lsu_uop_t LSU_UOP_NOP = lsu_uop_t'{
    is_nop:   1'b1,
    is_load:  1'b0,
    zero_ext: 1'b0,
    size:     2'd0,
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    imm:      '0
  };

endpackage

// File: rtl/lsu_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module lsu_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count while inc is high, stopping at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lsu_stage_buf.sv
// LSU pipeline stage register for NUM_SLOTS parallel memory slots with valid/ready
// handshake, synchronous flush and a saturating back-pressure counter.
// Optional macro LSU_STAGE_SKID_EN adds a one-entry skid buffer so in_ready is
// driven from a flop instead of combinationally from out_ready.
module lsu_stage_buf
  import lsu_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned IMM_W     = 12,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  lsu_uop_t [NUM_SLOTS-1:0]       in_uop,
  output logic                           out_valid,
  input  logic                           out_ready,
  output lsu_uop_t [NUM_SLOTS-1:0]       out_uop,
  output logic [CNT_W-1:0]               stall_cnt
);

  // The uop struct lives in the package, so its immediate width is fixed there.
  if (IMM_W != LSU_IMM_W) begin : g_imm_w_mismatch
    $error("IMM_W must equal lsu_pkg::LSU_IMM_W");
  end

  localparam lsu_uop_t [NUM_SLOTS-1:0] NopBundle = {NUM_SLOTS{LSU_UOP_NOP}};

  lsu_uop_t [NUM_SLOTS-1:0] main_q, main_d;
  logic                     main_valid_q, main_valid_d;
  logic                     in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid_q && out_ready;

`ifdef LSU_STAGE_SKID_EN
  lsu_uop_t [NUM_SLOTS-1:0] skid_q, skid_d;
  logic                     skid_valid_q, skid_valid_d;

  // Accept only while the skid slot is free; purely a function of state.
  assign in_ready = !skid_valid_q;

  // Next state: flush clears both entries, skid refills main on an out transfer.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_d       = NopBundle;
      main_valid_d = 1'b0;
      skid_d       = NopBundle;
      skid_valid_d = 1'b0;
    end else if (out_xfer) begin
      if (skid_valid_q) begin
        // in_ready was low, so no new bundle can arrive this cycle.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d = in_uop;
      end else begin
        main_valid_d = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          main_d[i].is_nop = 1'b1;
        end
      end
    end else if (in_xfer) begin
      if (main_valid_q) begin
        skid_d       = in_uop;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = in_uop;
        main_valid_d = 1'b1;
      end
    end
  end

  // Skid storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q       <= NopBundle;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  // Ready whenever main is empty or is being drained this cycle.
  assign in_ready = !main_valid_q || out_ready;

  // Next state: flush wins, then load, then drain marks every slot as a NOP.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (flush) begin
      main_d       = NopBundle;
      main_valid_d = 1'b0;
    end else if (in_xfer) begin
      main_d       = in_uop;
      main_valid_d = 1'b1;
    end else if (out_xfer) begin
      main_valid_d = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        main_d[i].is_nop = 1'b1;
      end
    end
  end
`endif

  // Main register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= NopBundle;
      main_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_uop   = main_q;

  lsu_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_valid_q && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_lsu_stage_buf.sv
// Self-checking bench for lsu_stage_buf: directed table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_lsu_stage_buf;
  import lsu_pkg::*;

  localparam int unsigned NS      = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_W_S = 2;
  localparam int unsigned MAX_C   = (1 << CNT_W) - 1;
  localparam int unsigned MAX_S   = (1 << CNT_W_S) - 1;

  typedef lsu_uop_t [NS-1:0] bundle_t;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  bundle_t            in_uop;
  logic               out_valid;
  logic               out_ready;
  bundle_t            out_uop;
  logic [CNT_W-1:0]   stall_cnt;
  logic               in_ready_s;
  logic               out_valid_s;
  bundle_t            out_uop_s;
  logic [CNT_W_S-1:0] stall_cnt_s;

  lsu_stage_buf #(.NUM_SLOTS(NS), .IMM_W(12), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_uop(in_uop), .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
    .stall_cnt(stall_cnt)
  );

  lsu_stage_buf #(.NUM_SLOTS(NS), .IMM_W(12), .CNT_W(CNT_W_S)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_uop(in_uop), .out_valid(out_valid_s), .out_ready(out_ready), .out_uop(out_uop_s),
    .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bundles currently held, in arrival order (front is on the output).
  bundle_t     mq[$];
  bundle_t     m_disp;
  int unsigned m_cnt;
  int unsigned m_cnt_s;
  logic [4:0]  delivered[$];

  function automatic bundle_t nop_b();
    bundle_t b;
    for (int i = 0; i < NS; i++) begin
      b[i]        = '0;
      b[i].is_nop = 1'b1;
    end
    return b;
  endfunction

  function automatic bundle_t mk(input int rd);
    bundle_t b;
    for (int i = 0; i < NS; i++) begin
      b[i]         = '0;
      b[i].is_load = 1'b1;
      b[i].size    = LSU_SIZE_W;
      b[i].rs1     = 5'(i + 1);
      b[i].rd      = 5'(rd);
      b[i].imm     = 12'(rd * 3 + i);
    end
    return b;
  endfunction

  function automatic bundle_t rnd_b();
    bundle_t b;
    for (int i = 0; i < NS; i++) b[i] = $urandom;
    return b;
  endfunction

  function automatic bit m_in_ready(input bit ordy);
`ifdef LSU_STAGE_SKID_EN
    return (mq.size() < 2) || (ordy && (mq.size() < 2));
`else
    return (mq.size() == 0) || ordy;
`endif
  endfunction

  task automatic m_step(input bit r, input bit f, input bit iv, input bundle_t b,
                        input bit ordy);
    bundle_t last;
    bit      popped;
    bit      inr;
    if (r) begin
      mq.delete();
      m_disp  = nop_b();
      m_cnt   = 0;
      m_cnt_s = 0;
      return;
    end
    if (mq.size() > 0 && !ordy) begin
      if (m_cnt < MAX_C) m_cnt++;
      if (m_cnt_s < MAX_S) m_cnt_s++;
    end
    inr = m_in_ready(ordy);
    if (f) begin
      mq.delete();
      m_disp = nop_b();
      return;
    end
    popped = 1'b0;
    last   = m_disp;
    if (mq.size() > 0 && ordy) begin
      last   = mq.pop_front();
      popped = 1'b1;
    end
    if (iv && inr) mq.push_back(b);
    if (mq.size() > 0) begin
      m_disp = mq[0];
    end else if (popped) begin
      for (int i = 0; i < NS; i++) last[i].is_nop = 1'b1;
      m_disp = last;
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive, check in_ready, advance model, sample outputs after the edge.
  task automatic cyc(input bit r, input bit f, input bit iv, input bundle_t b, input bit ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_uop    = b;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, m_in_ready(ordy));
    if (!r && !f && out_valid && ordy) delivered.push_back(out_uop[0].rd);
    m_step(r, f, iv, b, ordy);
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_uop", out_uop, m_disp);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("out_valid_small", out_valid_s, mq.size() > 0);
    chk("stall_cnt_small", stall_cnt_s, m_cnt_s);
  endtask

  typedef struct {
    bit         iv;
    logic [4:0] rd;
    bit         ordy;
    bit         ev;
    logic [4:0] erd;
    bit         enop;
  } vec_t;

  vec_t    tbl[5];
  int      exp_small[6];
  bit      pend;
  bit      acc;
  bundle_t eb;

  initial begin
    tbl[0] = '{iv: 1, rd: 1, ordy: 1, ev: 1, erd: 1, enop: 0};
    tbl[1] = '{iv: 1, rd: 2, ordy: 1, ev: 1, erd: 2, enop: 0};
    tbl[2] = '{iv: 1, rd: 3, ordy: 1, ev: 1, erd: 3, enop: 0};
    tbl[3] = '{iv: 1, rd: 4, ordy: 1, ev: 1, erd: 4, enop: 0};
    tbl[4] = '{iv: 0, rd: 0, ordy: 1, ev: 0, erd: 4, enop: 1};
    exp_small = '{1, 2, 3, 3, 3, 3};

    // Reset held two cycles with in_valid high.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_uop = mk(3); out_ready = 1'b0;
    m_step(1'b1, 1'b0, 1'b1, mk(3), 1'b0);
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b1, mk(3), 1'b0);
    chk("t1_out_valid", out_valid, 1'b0);
    chk("t1_nop", out_uop, nop_b());
    chk("t1_stall", stall_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0, mk(0), 1'b0);
    chk("t1_in_ready", in_ready, 1'b1);

    // Back-to-back stream of rd=1..4 followed by a drain.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, tbl[k].iv, mk(int'(tbl[k].rd)), tbl[k].ordy);
      chk("t2_valid", out_valid, tbl[k].ev);
      for (int s = 0; s < NS; s++) begin
        chk("t2_rd", out_uop[s].rd, tbl[k].erd);
        chk("t2_nop", out_uop[s].is_nop, tbl[k].enop);
      end
    end
    eb = mk(4);
    for (int s = 0; s < NS; s++) eb[s].is_nop = 1'b1;
    chk("t7_drain", out_uop, eb);

    // Back-pressure on rd=7 with rd=8 offered behind it.
    cyc(1'b1, 1'b0, 1'b0, mk(0), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(7), 1'b0);
    pend = 1'b1;
    for (int k = 0; k < 6; k++) begin
      acc = pend && m_in_ready(1'b0);
      cyc(1'b0, 1'b0, pend, mk(8), 1'b0);
      pend = pend && !acc;
      chk("t6_small_sat", stall_cnt_s, exp_small[k]);
      chk("t3_hold_rd", out_uop[0].rd, 7);
      if (k == 4) chk("t3_stall5", stall_cnt, 5);
    end
    chk("t3_in_ready", in_ready, 1'b0);
`ifdef LSU_STAGE_SKID_EN
    chk("t3_skid_took", pend, 1'b0);
`else
    chk("t3_no_take", pend, 1'b1);
`endif

    // Release: rd=7 then rd=8, each exactly once.
    delivered.delete();
    for (int k = 0; k < 6; k++) begin
      acc = pend && m_in_ready(1'b1);
      cyc(1'b0, 1'b0, pend, mk(8), 1'b1);
      pend = pend && !acc;
    end
    chk("t4_count", delivered.size(), 2);
    if (delivered.size() == 2) begin
      chk("t4_first", delivered[0], 7);
      chk("t4_second", delivered[1], 8);
    end

    // Flush with a held bundle and a competing rd=9 input.
    cyc(1'b0, 1'b0, 1'b1, mk(5), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, mk(9), 1'b0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_nop", out_uop, nop_b());
    delivered.delete();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, mk(0), 1'b1);
    chk("t5_no_rd9", delivered.size(), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(29) == 0), ($urandom_range(9) < 7),
          rnd_b(), ($urandom_range(9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
